// File: rtl/cv32e40p_x_offload_tracker_pkg.sv
// Shared XIF types and constants for the offload tracker and its scoreboard.
// Port bundles mirror the CORE-V-XIF issue/commit/result channels.
package cv32e40p_x_offload_tracker_pkg;

  localparam int unsigned XIF_ID_WIDTH = 4;
  localparam int unsigned XIF_NUM_GPR  = 32;
  localparam int unsigned RD_WIDTH     = 5;

  typedef struct packed {
    logic                valid;
    logic [RD_WIDTH-1:0] rd;
    logic                wb;
  } x_entry_t;

  typedef struct packed {
    logic                    valid;
    logic [XIF_ID_WIDTH-1:0] id;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
  } x_issue_resp_t;

  typedef struct packed {
    logic                    valid;
    logic [XIF_ID_WIDTH-1:0] id;
    logic                    kill;
  } x_commit_t;

  typedef struct packed {
    logic                    valid;
    logic [XIF_ID_WIDTH-1:0] id;
  } x_result_t;

  // Register 0 is hardwired, so only writebacks to rd != 0 occupy the scoreboard.
  function automatic logic rd_tracked(input logic [RD_WIDTH-1:0] rd, input logic wb);
    return wb && (rd != '0);
  endfunction

endpackage

// File: rtl/cv32e40p_x_rd_scoreboard.sv
// Destination-register busy vector: set on an accepted writeback offload,
// cleared when the matching result retires. Bit 0 never becomes busy.
module cv32e40p_x_rd_scoreboard
  import cv32e40p_x_offload_tracker_pkg::*;
#(
  parameter int unsigned NUM_GPR = XIF_NUM_GPR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_valid_i,
  input  logic [RD_WIDTH-1:0] set_rd_i,
  input  logic                clr_valid_i,
  input  logic [RD_WIDTH-1:0] clr_rd_i,
  output logic [NUM_GPR-1:0]  busy_o
);

  logic [NUM_GPR-1:0] busy_q;
  logic [NUM_GPR-1:0] busy_d;
  logic [NUM_GPR-1:0] set_mask;
  logic [NUM_GPR-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid_i) set_mask = NUM_GPR'(1) << set_rd_i;
    if (clr_valid_i) clr_mask = NUM_GPR'(1) << clr_rd_i;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/cv32e40p_x_offload_tracker.sv
// Core-side XIF offload tracker: allocates IDs, emits one commit per issue,
// tracks accepted offloads per ID and retires them on results.
module cv32e40p_x_offload_tracker
  import cv32e40p_x_offload_tracker_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH = XIF_ID_WIDTH,
  parameter int unsigned NUM_GPR    = XIF_NUM_GPR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  offload_valid_i,
  input  logic [RD_WIDTH-1:0]   offload_rd_i,
  input  logic                  offload_kill_i,
  output logic                  offload_ready_o,
  output logic                  x_issue_valid_o,
  input  logic                  x_issue_ready_i,
  output logic [X_ID_WIDTH-1:0] x_issue_id_o,
  input  logic                  x_issue_accept_i,
  input  logic                  x_issue_writeback_i,
  output logic                  x_commit_valid_o,
  output logic [X_ID_WIDTH-1:0] x_commit_id_o,
  output logic                  x_commit_kill_o,
  input  logic                  x_result_valid_i,
  output logic                  x_result_ready_o,
  input  logic [X_ID_WIDTH-1:0] x_result_id_i,
  output logic [NUM_GPR-1:0]    rd_busy_o,
  output logic [X_ID_WIDTH:0]   outstanding_o,
  output logic                  idle_o,
  output logic                  err_o
);

  localparam int unsigned NUM_ID = 2 ** X_ID_WIDTH;

  x_entry_t              entry_q [NUM_ID];
  x_entry_t              entry_d [NUM_ID];
  logic [X_ID_WIDTH-1:0] next_id_q;
  logic [X_ID_WIDTH:0]   outstanding_q;
  logic                  commit_valid_q;
  logic [X_ID_WIDTH-1:0] commit_id_q;
  logic                  commit_kill_q;
  logic                  err_q;
  logic                  result_ready_q;

  logic                  rd_blocked;
  logic                  issue_valid;
  logic                  issue_hs;
  logic                  alloc;
  logic                  res_fire;
  logic                  retire;
  x_entry_t              res_entry;
  logic [NUM_GPR-1:0]    rd_busy;

  // The scoreboard is registered, so a result freeing rd unblocks the issue one cycle later.
  assign rd_blocked  = rd_busy[offload_rd_i] & (offload_rd_i != '0);
  assign issue_valid = offload_valid_i & ~entry_q[next_id_q].valid & ~rd_blocked;
  assign issue_hs    = issue_valid & x_issue_ready_i;
  assign alloc       = issue_hs & x_issue_accept_i & ~offload_kill_i;
  assign res_fire    = x_result_valid_i & result_ready_q;
  assign res_entry   = entry_q[x_result_id_i];
  assign retire      = res_fire & res_entry.valid;

  // Allocation and retirement never target the same ID: allocation needs a free entry.
  always_comb begin
    for (int i = 0; i < int'(NUM_ID); i++) begin
      entry_d[i] = entry_q[i];
      if (retire && (x_result_id_i == X_ID_WIDTH'(i))) begin
        entry_d[i].valid = 1'b0;
      end
      if (alloc && (next_id_q == X_ID_WIDTH'(i))) begin
        entry_d[i].valid = 1'b1;
        entry_d[i].rd    = offload_rd_i;
        entry_d[i].wb    = x_issue_writeback_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_ID); i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_ID); i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_id_q      <= '0;
      outstanding_q  <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      commit_kill_q  <= 1'b0;
      err_q          <= 1'b0;
      result_ready_q <= 1'b0;
    end else begin
      result_ready_q <= 1'b1;
      err_q          <= res_fire & ~res_entry.valid;
      commit_valid_q <= issue_hs;
      if (issue_hs) begin
        next_id_q     <= next_id_q + 1'b1;
        commit_id_q   <= next_id_q;
        commit_kill_q <= offload_kill_i | ~x_issue_accept_i;
      end
      case ({alloc, retire})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  cv32e40p_x_rd_scoreboard #(
    .NUM_GPR (NUM_GPR)
  ) u_rd_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_valid_i (alloc & rd_tracked(offload_rd_i, x_issue_writeback_i)),
    .set_rd_i    (offload_rd_i),
    .clr_valid_i (retire & rd_tracked(res_entry.rd, res_entry.wb)),
    .clr_rd_i    (res_entry.rd),
    .busy_o      (rd_busy)
  );

  assign offload_ready_o  = issue_hs;
  assign x_issue_valid_o  = issue_valid;
  assign x_issue_id_o     = next_id_q;
  assign x_commit_valid_o = commit_valid_q;
  assign x_commit_id_o    = commit_id_q;
  assign x_commit_kill_o  = commit_kill_q;
  assign x_result_ready_o = result_ready_q;
  assign rd_busy_o        = rd_busy;
  assign outstanding_o    = outstanding_q;
  assign idle_o           = (outstanding_q == '0);
  assign err_o            = err_q;

endmodule

// File: tb/tb_cv32e40p_x_offload_tracker.sv
// Directed vector bench for the XIF offload tracker: a table of single-cycle
// transactions plus hand-written reset and full-table sequences.
module tb_cv32e40p_x_offload_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        offload_valid_i;
  logic [4:0]  offload_rd_i;
  logic        offload_kill_i;
  logic        offload_ready_o;
  logic        x_issue_valid_o;
  logic        x_issue_ready_i;
  logic [3:0]  x_issue_id_o;
  logic        x_issue_accept_i;
  logic        x_issue_writeback_i;
  logic        x_commit_valid_o;
  logic [3:0]  x_commit_id_o;
  logic        x_commit_kill_o;
  logic        x_result_valid_i;
  logic        x_result_ready_o;
  logic [3:0]  x_result_id_i;
  logic [31:0] rd_busy_o;
  logic [4:0]  outstanding_o;
  logic        idle_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_vec   = 0;

  always #5 clk = ~clk;

  cv32e40p_x_offload_tracker dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .offload_valid_i     (offload_valid_i),
    .offload_rd_i        (offload_rd_i),
    .offload_kill_i      (offload_kill_i),
    .offload_ready_o     (offload_ready_o),
    .x_issue_valid_o     (x_issue_valid_o),
    .x_issue_ready_i     (x_issue_ready_i),
    .x_issue_id_o        (x_issue_id_o),
    .x_issue_accept_i    (x_issue_accept_i),
    .x_issue_writeback_i (x_issue_writeback_i),
    .x_commit_valid_o    (x_commit_valid_o),
    .x_commit_id_o       (x_commit_id_o),
    .x_commit_kill_o     (x_commit_kill_o),
    .x_result_valid_i    (x_result_valid_i),
    .x_result_ready_o    (x_result_ready_o),
    .x_result_id_i       (x_result_id_i),
    .rd_busy_o           (rd_busy_o),
    .outstanding_o       (outstanding_o),
    .idle_o              (idle_o),
    .err_o               (err_o)
  );

  typedef struct {
    logic        ov;
    logic [4:0]  rd;
    logic        kill;
    logic        rdy;
    logic        acc;
    logic        wb;
    logic        rv;
    logic [3:0]  rid;
    logic        e_iv;
    logic [3:0]  e_iid;
    logic        e_cv;
    logic [3:0]  e_cid;
    logic        e_ck;
    logic [4:0]  e_out;
    logic        e_err;
    logic [31:0] e_busy;
  } vec_t;

  function automatic vec_t mk(input logic ov, input logic [4:0] rd, input logic kill,
                              input logic rdy, input logic acc, input logic wb,
                              input logic rv, input logic [3:0] rid,
                              input logic e_iv, input logic [3:0] e_iid,
                              input logic e_cv, input logic [3:0] e_cid, input logic e_ck,
                              input logic [4:0] e_out, input logic e_err, input logic [31:0] e_busy);
    vec_t v;
    v.ov = ov; v.rd = rd; v.kill = kill; v.rdy = rdy; v.acc = acc; v.wb = wb;
    v.rv = rv; v.rid = rid; v.e_iv = e_iv; v.e_iid = e_iid; v.e_cv = e_cv;
    v.e_cid = e_cid; v.e_ck = e_ck; v.e_out = e_out; v.e_err = e_err; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    offload_valid_i     = 1'b0;
    offload_rd_i        = '0;
    offload_kill_i      = 1'b0;
    x_issue_ready_i     = 1'b0;
    x_issue_accept_i    = 1'b0;
    x_issue_writeback_i = 1'b0;
    x_result_valid_i    = 1'b0;
    x_result_id_i       = '0;
  endtask

  // Drive on the falling edge, check combinational issue outputs before the
  // rising edge and registered outputs just after it.
  task automatic apply(input vec_t v);
    @(negedge clk);
    offload_valid_i     = v.ov;
    offload_rd_i        = v.rd;
    offload_kill_i      = v.kill;
    x_issue_ready_i     = v.rdy;
    x_issue_accept_i    = v.acc;
    x_issue_writeback_i = v.wb;
    x_result_valid_i    = v.rv;
    x_result_id_i       = v.rid;
    #1;
    chk("issue_valid", 32'(x_issue_valid_o), 32'(v.e_iv));
    chk("issue_id", 32'(x_issue_id_o), 32'(v.e_iid));
    chk("offload_ready", 32'(offload_ready_o), 32'(v.e_iv & v.rdy));
    @(posedge clk);
    #1;
    chk("commit_valid", 32'(x_commit_valid_o), 32'(v.e_cv));
    if (v.e_cv) begin
      chk("commit_id", 32'(x_commit_id_o), 32'(v.e_cid));
      chk("commit_kill", 32'(x_commit_kill_o), 32'(v.e_ck));
    end
    chk("outstanding", 32'(outstanding_o), 32'(v.e_out));
    chk("idle", 32'(idle_o), 32'(v.e_out == 5'd0));
    chk("err", 32'(err_o), 32'(v.e_err));
    chk("rd_busy", rd_busy_o, v.e_busy);
    $display("[TB] vec %0d: ov=%0b rd=%0d rdy=%0b acc=%0b kill=%0b wb=%0b rv=%0b rid=%0d -> cv=%0b cid=%0d ck=%0b out=%0d err=%0b busy=%08h",
             n_vec, v.ov, v.rd, v.rdy, v.acc, v.kill, v.wb, v.rv, v.rid,
             x_commit_valid_o, x_commit_id_o, x_commit_kill_o, outstanding_o, err_o, rd_busy_o);
    n_vec++;
  endtask

  vec_t vecs [15];

  initial begin
    // ov rd kill rdy acc wb rv rid | iv iid | cv cid ck | out err busy
    vecs[0]  = mk(1, 5,  0, 1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 32'h0000_0020);
    vecs[1]  = mk(0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
    vecs[2]  = mk(1, 3,  0, 1, 0, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 32'h0);
    vecs[3]  = mk(1, 9,  1, 1, 1, 1, 0, 0, 1, 2, 1, 2, 1, 0, 0, 32'h0);
    vecs[4]  = mk(0, 0,  0, 0, 0, 0, 1, 2, 0, 3, 0, 0, 0, 0, 1, 32'h0);
    vecs[5]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 32'h0);
    vecs[6]  = mk(1, 7,  0, 1, 1, 1, 0, 0, 1, 3, 1, 3, 0, 1, 0, 32'h0000_0080);
    vecs[7]  = mk(1, 7,  0, 1, 1, 1, 0, 0, 0, 4, 0, 0, 0, 1, 0, 32'h0000_0080);
    vecs[8]  = mk(1, 7,  0, 1, 1, 1, 1, 3, 0, 4, 0, 0, 0, 0, 0, 32'h0);
    vecs[9]  = mk(1, 7,  0, 1, 1, 1, 0, 0, 1, 4, 1, 4, 0, 1, 0, 32'h0000_0080);
    vecs[10] = mk(1, 10, 0, 1, 1, 0, 1, 4, 1, 5, 1, 5, 0, 1, 0, 32'h0);
    vecs[11] = mk(0, 0,  0, 0, 0, 0, 1, 5, 0, 6, 0, 0, 0, 0, 0, 32'h0);
    vecs[12] = mk(1, 1,  0, 0, 1, 1, 0, 0, 1, 6, 0, 0, 0, 0, 0, 32'h0);
    vecs[13] = mk(1, 0,  0, 1, 1, 1, 0, 0, 1, 6, 1, 6, 0, 1, 0, 32'h0);
    vecs[14] = mk(0, 0,  0, 0, 0, 0, 1, 6, 0, 7, 0, 0, 0, 0, 0, 32'h0);

    drive_idle();
    rst_n = 1'b0;
    #12;
    chk("rst_result_ready", 32'(x_result_ready_o), 32'd0);
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_busy", rd_busy_o, 32'd0);
    chk("rst_commit_valid", 32'(x_commit_valid_o), 32'd0);
    chk("rst_commit_id", 32'(x_commit_id_o), 32'd0);
    chk("rst_commit_kill", 32'(x_commit_kill_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_issue_id", 32'(x_issue_id_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("result_ready_after_rst", 32'(x_result_ready_o), 32'd1);

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i]);
    end

    // Reset mid-stream right after a handshake: outputs clear without waiting for a clock.
    apply(mk(1, 12, 0, 1, 1, 1, 0, 0, 1, 7, 1, 7, 0, 1, 0, 32'h0000_1000));
    #2;
    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("midrst_commit_valid", 32'(x_commit_valid_o), 32'd0);
    chk("midrst_outstanding", 32'(outstanding_o), 32'd0);
    chk("midrst_idle", 32'(idle_o), 32'd1);
    chk("midrst_busy", rd_busy_o, 32'd0);
    chk("midrst_result_ready", 32'(x_result_ready_o), 32'd0);
    chk("midrst_issue_id", 32'(x_issue_id_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_result_ready_rel", 32'(x_result_ready_o), 32'd1);
    chk("midrst_commit_after", 32'(x_commit_valid_o), 32'd0);

    // Fill all 16 IDs, then check wrap-around stall and in-order reuse of ID 0.
    for (int i = 0; i < 16; i++) begin
      apply(mk(1, 5'(i + 1), 0, 1, 1, 0, 0, 0, 1, 4'(i), 1, 4'(i), 0, 5'(i + 1), 0, 32'h0));
    end
    apply(mk(1, 20, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16, 0, 32'h0));
    apply(mk(1, 20, 0, 1, 1, 0, 1, 3, 0, 0, 0, 0, 0, 15, 0, 32'h0));
    apply(mk(1, 20, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 14, 0, 32'h0));
    apply(mk(1, 20, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 15, 0, 32'h0));
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    chk("final_commit_idle", 32'(x_commit_valid_o), 32'd0);
    chk("final_issue_id", 32'(x_issue_id_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_x_offload_tracker.md
Name: cv32e40p_x_offload_tracker

Overview:
- Core-side companion to the CORE-V-XIF type package; sits between the ID stage and the XIF issue/commit/result channels.
- Allocates transaction IDs, drives one commit per issued instruction, and records accepted offloads in a table indexed by ID.
- Retires table entries on result handshakes and exports a destination-register scoreboard for hazard stalls.

Parameters:
- X_ID_WIDTH, 4, width of the XIF transaction ID; the table holds NUM_ID = 2**X_ID_WIDTH entries.
- NUM_GPR, 32, number of integer registers tracked by the scoreboard.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- offload_valid_i  in  1  ID stage requests offload of the current instruction
- offload_rd_i  in  5  destination register of the request
- offload_kill_i  in  1  request will not retire (squash); sampled at handshake
- offload_ready_o  out  1  handshake done this cycle (= x_issue_valid_o & x_issue_ready_i)
- x_issue_valid_o  out  1  issue request to coprocessor
- x_issue_ready_i  in  1  coprocessor takes the issue
- x_issue_id_o  out  X_ID_WIDTH  ID of the current issue
- x_issue_accept_i  in  1  issue response: accept
- x_issue_writeback_i  in  1  issue response: writeback expected
- x_commit_valid_o  out  1  commit pulse
- x_commit_id_o  out  X_ID_WIDTH  ID being committed
- x_commit_kill_o  out  1  commit carries kill
- x_result_valid_i  in  1  result from coprocessor
- x_result_ready_o  out  1  always 1 after reset
- x_result_id_i  in  X_ID_WIDTH  ID of the result
- rd_busy_o  out  NUM_GPR  scoreboard; bit 0 is always 0
- outstanding_o  out  X_ID_WIDTH+1  number of valid table entries
- idle_o  out  1  outstanding_o == 0
- err_o  out  1  one-cycle pulse: result ID with no valid entry

Behaviour:
- Reset (async, rst_n=0):
  - all table entries invalid; next_id=0; rd_busy_o=0; outstanding_o=0; idle_o=1.
  - x_commit_valid_o=0, x_commit_id_o=0, x_commit_kill_o=0, err_o=0.
  - x_result_ready_o=0 while in reset, 1 from the first cycle after release.
  - A reset mid-operation discards all in-flight state with no commits emitted.
- Table entry: valid, rd[4:0], wb.
- Issue:
  - x_issue_valid_o = offload_valid_i & ~valid[next_id] & ~(rd_busy_o[offload_rd_i] & offload_rd_i!=0). Combinational, no added latency.
  - x_issue_id_o = next_id.
  - Once valid is raised it is held while the ID stage holds offload_valid_i.
- Issue handshake (valid & ready):
  - next_id increments modulo NUM_ID.
  - Allocate entry[next_id] only if accept & ~offload_kill_i: rd <= offload_rd_i, wb <= writeback.
  - Set rd_busy[rd] when wb=1 and rd != 0.
- Commit: registered, exactly one cycle after every issue handshake, including rejected and killed issues.
  - x_commit_id_o = handshaken ID.
  - x_commit_kill_o = offload_kill_i | ~x_issue_accept_i.
  - Back-to-back handshakes give back-to-back commit pulses.
- Result (x_result_valid_i):
  - If valid[x_result_id_i]: clear the entry and, if its wb=1, clear rd_busy[rd].
  - Otherwise the result is ignored and err_o pulses in the next cycle.
- Simultaneous events:
  - Issue allocation and result retirement in the same cycle both apply; outstanding_o is unchanged.
  - They cannot hit the same ID, because allocation requires the entry to be free.
  - A result clearing rd_busy[r] does not unblock an issue to r in the same cycle; the issue proceeds one cycle later (registered scoreboard).
- Full: when valid[next_id]=1 (ID wrap-around onto a live entry), issue stalls until that ID retires. Later IDs are not skipped.
- outstanding_o is a registered count: +1 on allocation, -1 on valid retirement. It never exceeds NUM_ID.

Decomposition:
- Shared XIF package: X_ID_WIDTH and the issue/commit/result struct types. Use those structs for the port bundles if the top level prefers.
- Scoreboard: a natural sub-module, cv32e40p_x_rd_scoreboard, with set/clear ports and a busy vector. The table and commit register stay in the parent.

Test Plan:
- Reset, then issue rd=5 with accept=1, wb=1, ID 0 -> commit(id0, kill=0) next cycle; rd_busy_o[5]=1; outstanding_o=1; result id0 -> rd_busy_o[5]=0, idle_o=1.
- Issue with accept=0 -> commit kill=1; no entry; outstanding_o stays 0; next_id=1.
- Issue with offload_kill_i=1 and accept=1 -> commit kill=1; rd not busy; a later result with that ID -> err_o pulse, state unchanged.
- 16 accepted wb=0 issues with no results -> outstanding_o=16; the 17th request holds x_issue_valid_o=0; result id3 arrives -> still stalled (next_id=0 busy); result id0 -> issue proceeds with ID 0.
- Issue to rd=7 while rd 7 is busy -> valid held low; result frees rd 7 in cycle N -> issue fires in cycle N+1.
- Issue handshake and result for a different ID in the same cycle -> outstanding_o unchanged; commit pulse next cycle. Assert rst_n mid-stream -> all outputs return to reset values immediately.
